// File: rtl/mem_copy_engine_if.sv
// Memory-side port bundle between the copy engine and a single-port-write,
// async-read word memory.
// Ports: mem_ren/mem_raddr -> read request, mem_rdata <- combinational read data,
//        mem_wen/mem_waddr/mem_wdata -> write request (committed on the rising edge).
interface mem_copy_engine_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic          mem_wen;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   // master: the copy engine; slave: the memory
   modport master (
      output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_copy_engine.sv
// In-memory word copy engine: moves len words from src_addr to dst_addr, ascending.
// Latency: one word per two clocks (RD then WR); done pulses at cycle 2*len+1 after start.
// Backpressure: none; start is only sampled in IDLE, abort cancels RD/WR at the next edge.
// Ports: clk, rst_n (async active-low); command start/src_addr/dst_addr/len/abort;
//        status busy/done/err/checksum; memory port through mem_copy_engine_if.master.
module mem_copy_engine #(
   parameter int DEPTH = 1024,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [10:0]   len,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] checksum,
   mem_copy_engine_if.master mem
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_src;
   logic [AW-1:0] r_dst;
   logic [10:0]   r_len;
   logic [10:0]   r_idx;
   logic [DW-1:0] r_data;
   logic [DW-1:0] r_checksum;

   logic          w_cmd;
   logic          w_len_zero;
   logic          w_range_bad;
   logic          w_last;
   logic [AW:0]   w_src_end;
   logic [AW:0]   w_dst_end;

   // End addresses are formed one bit wider so a source near the top of the
   // address space cannot wrap around and slip past the range check.
   assign w_src_end   = {1'b0, src_addr} + (AW+1)'(len);
   assign w_dst_end   = {1'b0, dst_addr} + (AW+1)'(len);
   assign w_range_bad = (w_src_end > LP_DEPTH) || (w_dst_end > LP_DEPTH);
   assign w_cmd       = start && !abort;
   assign w_len_zero  = (len == 11'd0);
   // r_len is never 0 while in RD/WR, so the subtraction cannot underflow there.
   assign w_last      = (r_idx == (r_len - 11'd1));
   assign checksum    = r_checksum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      busy          = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      mem.mem_ren   = 1'b0;
      mem.mem_raddr = '0;
      mem.mem_wen   = 1'b0;
      mem.mem_waddr = '0;
      mem.mem_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            // A zero-length command completes without touching memory,
            // even if its addresses lie outside the memory.
            if (w_cmd) begin
               if (w_len_zero) begin
                  w_next = ST_DONE;
               end else if (w_range_bad) begin
                  w_next = ST_ERR;
               end else begin
                  w_next = ST_RD;
               end
            end
         end
         ST_RD: begin
            busy          = 1'b1;
            mem.mem_ren   = 1'b1;
            mem.mem_raddr = r_src + AW'(r_idx);
            w_next        = abort ? ST_IDLE : ST_WR;
         end
         ST_WR: begin
            busy          = 1'b1;
            mem.mem_wen   = 1'b1;
            mem.mem_waddr = r_dst + AW'(r_idx);
            mem.mem_wdata = r_data;
            if (abort) begin
               w_next = ST_IDLE;
            end else if (w_last) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_RD;
            end
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         ST_ERR: begin
            err    = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src      <= '0;
         r_dst      <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_data     <= '0;
         r_checksum <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd && w_len_zero) begin
                  r_checksum <= '0;
               end else if (w_cmd && !w_range_bad) begin
                  r_src      <= src_addr;
                  r_dst      <= dst_addr;
                  r_len      <= len;
                  r_idx      <= '0;
                  r_checksum <= '0;
               end
            end
            ST_RD: begin
               r_data <= mem.mem_rdata;
            end
            ST_WR: begin
               // The write lands on this edge even when aborting, so the word
               // is counted; the checksum then holds that partial sum.
               r_checksum <= r_checksum + r_data;
               if (!abort && !w_last) begin
                  r_idx <= r_idx + 11'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
